// File: rtl/evfifo_reader.sv
// evfifo_reader
//   Drains the event-arrival log (evFIFO) on the system clock. It polls the
//   log's write pointer and fetches each new entry through the log's CSR/GPIO
//   port. Each entry is emitted as a 40-bit {event, ticks} word on a
//   valid/ready stream. If the write pointer is about to lap the read
//   pointer, logging is stopped and overrun is raised.
//
// Parameters
//   ADDR_WIDTH  log depth exponent (must match the log instance)
//   MARGIN      overrun fires when unread >= 2^ADDR_WIDTH - MARGIN
//   POLL_GAP    idle cycles between pointer polls while the log is empty
//
// Ports
//   sysClk        system clock (only clock used)
//   sysReset      asynchronous active-high reset
//   enable        level: 1 = run logging/draining, 0 = stop
//   sysCsrStrobe  one-cycle strobe to the log, latches sysGpioOut
//   sysGpioOut    [31] running, [ADDR_WIDTH-1:0] read address, rest 0
//   sysCsr        [31] running, [23:16] event at read addr, [15:0] write ptr
//   sysDataTicks  tick stamp at read address
//   mTdata        {event[7:0], ticks[31:0]}
//   mTvalid       stream valid
//   mTready       stream ready
//   overrun       sticky overrun flag, cleared when enable falls
//   entryCount    entries emitted since the last enable rise (wraps)
//
// Build option
//   EVFIFO_READER_TIMESTAMP_DELTA_EN: when defined, mTdata[31:0] carries
//   ticks minus the previously emitted ticks (first entry after START is 0).
//   When undefined, mTdata[31:0] carries the raw ticks.

module evfifo_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MARGIN     = 16,
  parameter int unsigned POLL_GAP   = 8
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic        enable,
  output logic        sysCsrStrobe,
  output logic [31:0] sysGpioOut,
  input  logic [31:0] sysCsr,
  input  logic [31:0] sysDataTicks,
  output logic [39:0] mTdata,
  output logic        mTvalid,
  input  logic        mTready,
  output logic        overrun,
  output logic [31:0] entryCount
);

  localparam logic [ADDR_WIDTH-1:0] OVR_LIMIT =
    ADDR_WIDTH'((1 << ADDR_WIDTH) - MARGIN);
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, START, POLL, SAMPLE, GAP, ADDR, WAIT_RAM, LOAD, OUT,
    STOP, HALT, DSTOP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [ADDR_WIDTH-1:0] wrA;
  logic [ADDR_WIDTH-1:0] unread;
  logic [GAP_W-1:0]      gapCnt;

  logic [ADDR_WIDTH-1:0] wrNow;
  logic [ADDR_WIDTH-1:0] unreadNow;
  logic [31:0]           ticksField;
  logic                  unusedCsrBits;

  assign wrNow         = sysCsr[ADDR_WIDTH-1:0];
  assign unreadNow     = wrNow - rdAddr;
  assign unusedCsrBits = ^{sysCsr[31:24], sysCsr[15:ADDR_WIDTH]};

`ifdef EVFIFO_READER_TIMESTAMP_DELTA_EN
  logic [31:0] prevTicks;
  logic [31:0] curTicks;
  logic        firstEntry;
  assign ticksField = firstEntry ? '0 : (sysDataTicks - prevTicks);
`else
  assign ticksField = sysDataTicks;
`endif

  function automatic logic [31:0] gpioWord(input logic run,
                                           input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] w;
    w                 = '0;
    w[31]             = run;
    w[ADDR_WIDTH-1:0] = addr;
    return w;
  endfunction

  // Strobe and GPIO are set on the transition into ADDR/START/STOP/DSTOP so
  // the strobe is high during that state's cycle; LOAD then lands exactly
  // two cycles later, when the log's RAM output is valid.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state        <= IDLE;
      sysCsrStrobe <= 1'b0;
      sysGpioOut   <= '0;
      mTdata       <= '0;
      mTvalid      <= 1'b0;
      overrun      <= 1'b0;
      entryCount   <= '0;
      rdAddr       <= '0;
      wrA          <= '0;
      unread       <= '0;
      gapCnt       <= '0;
`ifdef EVFIFO_READER_TIMESTAMP_DELTA_EN
      prevTicks    <= '0;
      curTicks     <= '0;
      firstEntry   <= 1'b1;
`endif
    end else begin
      sysCsrStrobe <= 1'b0;
      // Disable aborts every active state except OUT, which must finish the
      // word it is already presenting.
      if (!enable && (state inside {START, POLL, SAMPLE, GAP, ADDR,
                                    WAIT_RAM, LOAD})) begin
        state        <= DSTOP;
        sysCsrStrobe <= 1'b1;
        sysGpioOut   <= gpioWord(1'b0, '0);
      end else begin
        case (state)
          IDLE: begin
            if (enable) begin
              state        <= START;
              sysCsrStrobe <= 1'b1;
              sysGpioOut   <= gpioWord(1'b1, '0);
              rdAddr       <= '0;
              entryCount   <= '0;
`ifdef EVFIFO_READER_TIMESTAMP_DELTA_EN
              prevTicks    <= '0;
              firstEntry   <= 1'b1;
`endif
            end
          end
          START: state <= POLL;
          POLL: begin
            wrA   <= wrNow;
            state <= SAMPLE;
          end
          SAMPLE: begin
            // Pointer crosses clocks unsynchronised: accept only when two
            // consecutive samples agree.
            if (wrNow != wrA) begin
              state <= POLL;
            end else if (unreadNow >= OVR_LIMIT) begin
              state        <= STOP;
              sysCsrStrobe <= 1'b1;
              sysGpioOut   <= gpioWord(1'b0, '0);
            end else if (unreadNow == '0) begin
              gapCnt <= '0;
              state  <= (POLL_GAP == 0) ? POLL : GAP;
            end else begin
              unread       <= unreadNow;
              state        <= ADDR;
              sysCsrStrobe <= 1'b1;
              sysGpioOut   <= gpioWord(1'b1, rdAddr);
            end
          end
          GAP: begin
            if (gapCnt == GAP_LAST) state <= POLL;
            else gapCnt <= gapCnt + GAP_W'(1);
          end
          ADDR:     state <= WAIT_RAM;
          WAIT_RAM: state <= LOAD;
          LOAD: begin
            mTdata  <= {sysCsr[23:16], ticksField};
            mTvalid <= 1'b1;
            state   <= OUT;
`ifdef EVFIFO_READER_TIMESTAMP_DELTA_EN
            curTicks <= sysDataTicks;
`endif
          end
          OUT: begin
            if (mTready) begin
              mTvalid    <= 1'b0;
              rdAddr     <= rdAddr + ADDR_WIDTH'(1);
              entryCount <= entryCount + 32'd1;
              unread     <= unread - ADDR_WIDTH'(1);
`ifdef EVFIFO_READER_TIMESTAMP_DELTA_EN
              prevTicks  <= curTicks;
              firstEntry <= 1'b0;
`endif
              if (!enable) begin
                state        <= DSTOP;
                sysCsrStrobe <= 1'b1;
                sysGpioOut   <= gpioWord(1'b0, '0);
              end else if (unread != ADDR_WIDTH'(1)) begin
                state        <= ADDR;
                sysCsrStrobe <= 1'b1;
                sysGpioOut   <= gpioWord(1'b1, rdAddr + ADDR_WIDTH'(1));
              end else begin
                state <= POLL;
              end
            end
          end
          STOP: begin
            overrun <= 1'b1;
            state   <= HALT;
          end
          HALT: begin
            if (!enable) begin
              overrun <= 1'b0;
              state   <= IDLE;
            end
          end
          DSTOP:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/evfifo_reader.md
# evfifo_reader

Drains the event-arrival log on the system clock and turns it into a stream. It polls the log's write pointer, reads each new entry through the log's CSR/GPIO port, and emits a 40-bit {event, ticks} word on a valid/ready stream. It detects imminent pointer lap (overrun), stops logging, and reports it. It sits directly downstream of the event log (evFIFO), between that log and the stream consumer (DMA / packetiser).

## Interface
- ADDR_WIDTH, 10, log depth exponent; must match the log instance.
- MARGIN, 16, overrun threshold; overrun fires when unread count ≥ 2^ADDR_WIDTH − MARGIN.
- POLL_GAP, 8, idle cycles between write-pointer polls when the log is empty.
- sysClk  in  1  system clock; the block uses only this clock.
- sysReset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run logging and draining, 0 = stop.
- sysCsrStrobe  out  1  one-cycle strobe to the log; latches sysGpioOut.
- sysGpioOut  out  32  bit31 = running, bits[ADDR_WIDTH-1:0] = read address, all other bits 0.
- sysCsr  in  32  log status: [31] running, [23:16] event at read address, [15:0] write pointer.
- sysDataTicks  in  32  tick stamp at read address.
- mTdata  out  40  {event[7:0], ticks[31:0]}.
- mTvalid  out  1  stream valid.
- mTready  in  1  stream ready.
- overrun  out  1  sticky; cleared when enable falls.
- entryCount  out  32  entries emitted since the last enable rise; wraps.

## Operation
- Reset values: sysCsrStrobe=0, sysGpioOut=0, mTdata=0, mTvalid=0, overrun=0, entryCount=0, rdAddr=0, state IDLE.
- States and transitions:
  - IDLE: wait for enable=1.
  - START: pulse strobe with running=1, address 0. Clear entryCount.
  - POLL: capture wrA = sysCsr[ADDR_WIDTH-1:0].
  - SAMPLE: capture wrB the next cycle. If wrA≠wrB, go back to POLL. Reason: the write pointer crosses clock domains unsynchronised, so it is accepted only when two consecutive samples agree.
  - Evaluate: unread = (wrB − rdAddr) mod 2^ADDR_WIDTH.
    - unread ≥ 2^ADDR_WIDTH − MARGIN: go to STOP.
    - unread = 0: wait POLL_GAP cycles, then go to POLL.
    - Otherwise: go to ADDR.
  - ADDR: pulse strobe with running=1 and address rdAddr.
  - WAIT: one cycle.
  - LOAD: capture {sysCsr[23:16], sysDataTicks} into mTdata. Assert mTvalid.
  - OUT: hold mTdata and mTvalid until mTready. On the handshake, increment rdAddr mod 2^ADDR_WIDTH and entryCount. Decrement unread.
    - unread still > 0: go to ADDR without re-polling.
    - Otherwise: go to POLL.
  - STOP: pulse strobe with running=0 and address 0. Set overrun. Go to HALT.
  - HALT: wait for enable=0, then go to IDLE. overrun clears on that enable=0.
- Disabling:
  - enable=0 in any state other than IDLE/HALT: finish a pending OUT handshake only if mTvalid is already high (never drop a presented word), then go to a stop state.
  - That stop state pulses strobe with running=0, address 0, without setting overrun, then goes to IDLE.
- sysGpioOut is registered and holds its last value between strobes.
- The log restarts its write pointer at 0 on running, so rdAddr resets to 0 on every START.

## Timing
- The strobe is driven in cycle T. The log registers the address at T+1, and its RAM output is valid at T+2. LOAD samples at T+2, and mTvalid rises at T+3.
- Best-case throughput is one entry per 4 cycles with mTready held at 1.
- Poll cost is 2 cycles, plus POLL_GAP when the log is empty.
- mTvalid, once high, stays high with mTdata stable until mTready=1 (AXI-stream rule). It never depends combinationally on mTready.
- Reset asserted mid-transfer drops mTvalid immediately (asynchronous).

## Configuration
- EVFIFO_READER_TIMESTAMP_DELTA_EN:
  - Defined: mTdata[31:0] = ticks − previous emitted ticks, mod 2^32. The first entry after START carries 0. The previous value updates only on a handshake.
  - Undefined: mTdata[31:0] = raw ticks.
  - mTdata[39:32] is unaffected in both cases.

## Test plan
- Reset then enable=1 → first strobe with sysGpioOut=0x8000_0000. No mTvalid while sysCsr[15:0]=0.
- Log model holds entries {0x25, 100}, {0x26, 250}, pointer=2, with mTready=1 → words 0x25_0000_0064 and then 0x26_0000_00FA. entryCount=2. A new poll follows. With the delta macro defined, the ticks fields are 0 and 150.
- mTready held at 0 for 20 cycles with one entry pending → mTvalid stays 1 and mTdata stays stable. No further strobe is issued until the handshake.
- Pointer sampled as 0x003 then 0x004 → no read. A resample is taken, and 4 entries are read once two samples agree.
- ADDR_WIDTH=10, MARGIN=16, pointer=1008 with rdAddr=0 → strobe with sysGpioOut=0. overrun=1. Then enable=0 clears overrun and the block returns to IDLE.
- Read wrap: rdAddr=1023 with pointer=1 → two entries are read, from addresses 1023 and 0. rdAddr ends at 1.
